// File: rtl/sparrow_dmem_bridge_if.sv
// Bus side of the Sparrow data-memory bridge: address phase (req/gnt)
// followed by exactly one response (rvalid) per granted request.
interface sparrow_dmem_bridge_if;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/sparrow_dmem_bridge.sv
// Core load/store port to word bus bridge: lane steering, byte strobes,
// alignment checking, grant timeout, one outstanding access.
module sparrow_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         core_req_i,
    input  logic [31:0]                  core_addr_i,
    input  logic [1:0]                   core_size_i,
    input  logic                         core_wr_i,
    input  logic [31:0]                  core_wr_data_i,
    output logic [31:0]                  core_rd_data_o,
    output logic                         core_stall_o,
    output logic                         core_err_o,
    sparrow_dmem_bridge_if.master        bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    logic        legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        legal     = 1'b0;
        be_new    = 4'b0000;
        wdata_new = 32'h0;
        case (core_size_i)
            2'b00: begin
                legal     = 1'b1;
                be_new    = 4'b0001 << core_addr_i[1:0];
                wdata_new = {4{core_wr_data_i[7:0]}};
            end
            2'b01: begin
                legal     = ~core_addr_i[0];
                be_new    = 4'b0011 << core_addr_i[1:0];
                wdata_new = {2{core_wr_data_i[15:0]}};
            end
            2'b10: begin
                legal     = (core_addr_i[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = core_wr_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        // Capture registers are only non-zero for the single DONE cycle.
        rd_data_d   = 32'h0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    off_d = core_addr_i[1:0];
                    if (legal) begin
                        state_d     = S_ADDR;
                        cnt_d       = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = {core_addr_i[31:2], 2'b00};
                        bus_we_d    = core_wr_i;
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (bus.bus_gnt_i) begin
                    state_d   = S_WAIT;
                    bus_req_d = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (bus.bus_rvalid_i) begin
                    state_d     = S_DONE;
                    rd_data_d   = bus_we_q ? 32'h0 : (bus.bus_rdata_i >> {off_q, 3'b000});
                    err_d       = bus.bus_err_i;
                    bus_addr_d  = 32'h0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
                end
            end
            S_DONE: begin
                // The request seen here is the one completing; never start another.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            rd_data_q   <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    // Gated by reset_n so the core is released the instant reset asserts.
    assign core_stall_o    = reset_n & core_req_i & (state_q != S_DONE);
    assign core_rd_data_o  = rd_data_q;
    assign core_err_o      = err_q;
    assign bus.bus_req_o   = bus_req_q;
    assign bus.bus_addr_o  = bus_addr_q;
    assign bus.bus_we_o    = bus_we_q;
    assign bus.bus_be_o    = bus_be_q;
    assign bus.bus_wdata_o = bus_wdata_q;

endmodule
